// File: rtl/usr_transfer_ctrl.sv
// Word transfer sequencer around a universal shift register.
// Runs one TX (parallel-to-serial) or RX (serial-to-parallel) word per start.
module usr_transfer_ctrl #(
   parameter int data_bitsize = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    mode,
   input  logic                    dir,
   input  logic [data_bitsize-1:0] din,
   input  logic                    sin,
   output logic                    sout,
   output logic                    sout_valid,
   output logic [data_bitsize-1:0] dout,
   output logic                    busy,
   output logic                    done
);

   localparam int W     = data_bitsize;
   localparam int CNT_W = $clog2(data_bitsize) + 1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             mode_q;
   logic             dir_q;
   logic [W-1:0]     sreg;
   logic [W-1:0]     sreg_shift;
   logic [CNT_W-1:0] cnt;
   logic             last;
   logic             sbit;

   assign last = (cnt == CNT_W'(W - 1));
   assign sbit = mode_q & sin;

   // TX feeds zeros in, so the register drains to all-zero
   assign sreg_shift = dir_q ? {sreg[W-2:0], sbit}
                             : {sbit, sreg[W-1:1]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      busy       = 1'b1;
      done       = 1'b0;
      sout       = 1'b0;
      sout_valid = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            state_nxt = SHIFT;
         end
         SHIFT: begin
            sout_valid = ~mode_q;
            sout       = ~mode_q & (dir_q ? sreg[W-1] : sreg[0]);
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q <= 1'b0;
         dir_q  <= 1'b0;
         sreg   <= '0;
         cnt    <= '0;
         dout   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  mode_q <= mode;
                  dir_q  <= dir;
               end
            end
            LOAD: begin
               sreg <= mode_q ? '0 : din;
               cnt  <= '0;
            end
            SHIFT: begin
               sreg <= sreg_shift;
               cnt  <= cnt + 1'b1;
               if (last) begin
                  dout <= sreg_shift;
               end
            end
            DONE: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usr_transfer_ctrl.sv
// Directed testbench for usr_transfer_ctrl (W = 4).
// Inputs driven and outputs sampled on the falling edge.
module tb_usr_transfer_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       mode;
   logic       dir;
   logic [3:0] din;
   logic       sin;
   logic       sout;
   logic       sout_valid;
   logic [3:0] dout;
   logic       busy;
   logic       done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   usr_transfer_ctrl #(.data_bitsize(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .mode       (mode),
      .dir        (dir),
      .din        (din),
      .sin        (sin),
      .sout       (sout),
      .sout_valid (sout_valid),
      .dout       (dout),
      .busy       (busy),
      .done       (done)
   );

   // One full transfer with inline checks; exp_seq[i] is the i-th bit out
   task automatic do_transfer(input logic m, input logic d,
                              input logic [3:0] word,
                              input logic [3:0] sbits,
                              input logic [3:0] exp_seq,
                              input logic [3:0] exp_dout,
                              input string nm);
      @(negedge clk);
      start = 1'b1; mode = m; dir = d; din = word;
      @(negedge clk);
      start = 1'b0; mode = ~m; dir = ~d;
      checks++;
      if (busy !== 1'b1 || sout_valid !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL %s_load: busy=%b sv=%b done=%b required 1 0 0",
                  nm, busy, sout_valid, done);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) din = ~word;
         sin = sbits[i];
         checks++;
         if (sout_valid !== ~m || sout !== (~m & exp_seq[i]) ||
             done !== 1'b0) begin
            failures++;
            $display("FAIL %s_shift%0d: sv=%b sout=%b done=%b required %b %b 0",
                     nm, i, sout_valid, sout, done, ~m, ~m & exp_seq[i]);
         end
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || dout !== exp_dout) begin
         failures++;
         $display("FAIL %s_done: done=%b busy=%b dout=%b required 1 1 %b",
                  nm, done, busy, dout, exp_dout);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || dout !== exp_dout) begin
         failures++;
         $display("FAIL %s_idle: done=%b busy=%b dout=%b required 0 0 %b",
                  nm, done, busy, dout, exp_dout);
      end
   endtask

   task automatic test_reset;
      int nbusy;
      reset = 1'b1; start = 1'b0; mode = 1'b0; dir = 1'b0;
      din = 4'h0; sin = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({sout, sout_valid, dout, busy, done} !== 8'h00) begin
         failures++;
         $display("FAIL reset_outputs: got %b required 00000000",
                  {sout, sout_valid, dout, busy, done});
      end
      reset = 1'b0;
      nbusy = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (busy || done || sout_valid || sout) nbusy++;
      end
      checks++;
      if (nbusy !== 0) begin
         failures++;
         $display("FAIL idle_quiet: active cycles=%0d required 0", nbusy);
      end
   endtask

   task automatic test_tx_right;
      do_transfer(1'b0, 1'b0, 4'b1011, 4'b0000, 4'b1011, 4'b0000, "tx_right");
   endtask

   task automatic test_tx_left;
      int         n;
      int         k;
      logic [3:0] got;
      got = 4'b0000;
      @(negedge clk);
      start = 1'b1; mode = 1'b0; dir = 1'b1; din = 4'b1011;
      @(negedge clk);
      start = 1'b0;
      n = 0; k = 0;
      while (busy && n < 20) begin
         if (sout_valid && k < 4) begin
            got[k] = sout;
            k++;
         end
         n++;
         @(negedge clk);
      end
      checks++;
      if (n !== 6) begin
         failures++;
         $display("FAIL tx_left_busy: cycles=%0d required 6", n);
      end
      checks++;
      if (k !== 4 || got !== 4'b1101) begin
         failures++;
         $display("FAIL tx_left_sout: bits=%0d seq=%b required 4 1101", k, got);
      end
      checks++;
      if (dout !== 4'b0000) begin
         failures++;
         $display("FAIL tx_left_dout: got %b required 0000", dout);
      end
   endtask

   task automatic test_rx;
      do_transfer(1'b1, 1'b0, 4'b1111, 4'b0011, 4'b0000, 4'b0011, "rx_right");
      do_transfer(1'b1, 1'b1, 4'b1111, 4'b0011, 4'b0000, 4'b1100, "rx_left");
   endtask

   task automatic test_start_ignored;
      logic [3:0] got;
      got = 4'b0000;
      @(negedge clk);
      start = 1'b1; mode = 1'b0; dir = 1'b0; din = 4'b1011;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         got[i] = sout;
         start = (i == 1);
         din = 4'b0100; mode = 1'b1; dir = 1'b1;
      end
      start = 1'b0;
      checks++;
      if (got !== 4'b1011) begin
         failures++;
         $display("FAIL ignore_sout: seq=%b required 1011", got);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL ignore_done: done=%b required 1", done);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL ignore_not_queued: busy=%b required 0", busy);
      end
   endtask

   task automatic test_reset_abort;
      int ndone;
      @(negedge clk);
      start = 1'b1; mode = 1'b1; dir = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      sin = 1'b1;
      @(negedge clk);
      sin = 1'b1;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL abort_pre: busy=%b required 1", busy);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || dout !== 4'b0000 || done !== 1'b0) begin
         failures++;
         $display("FAIL abort_state: busy=%b dout=%b done=%b required 0 0000 0",
                  busy, dout, done);
      end
      reset = 1'b0;
      ndone = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      checks++;
      if (ndone !== 0) begin
         failures++;
         $display("FAIL abort_no_done: active cycles=%0d required 0", ndone);
      end
      do_transfer(1'b1, 1'b0, 4'b0000, 4'b0101, 4'b0000, 4'b0101, "rx_after");
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      start = 1'b1; mode = 1'b0; dir = 1'b0; din = 4'b0110;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         checks++;
         if (busy !== !(c == 6 || c == 13) ||
             done !== (c == 5 || c == 12)) begin
            failures++;
            $display("FAIL b2b_cycle%0d: busy=%b done=%b required %b %b",
                     c, busy, done, !(c == 6 || c == 13),
                     (c == 5 || c == 12));
         end
         if (c == 12) start = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_tx_right();
      test_tx_left();
      test_rx();
      test_start_ignored();
      test_reset_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
